// File: rtl/srl_dly_bbl.sv
// Programmable-depth parallel delay line with flush, fill tracking and optional output register.
// Delay is counted in ce-qualified shifts: tap = sr[adr], i.e. the word written adr+1 shifts ago.
module srl_dly_bbl #(
  parameter int WIDTH = 19,
  parameter int ADRW  = 4,
  parameter int OREG  = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             flush,
  input  logic [ADRW-1:0]  adr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [ADRW:0]    fill
);

  localparam int            DEPTH    = 2 ** ADRW;
  localparam logic [ADRW:0] FILL_MAX = (ADRW + 1)'(DEPTH);
  localparam logic [ADRW:0] FILL_ONE = (ADRW + 1)'(1);

  // Fabric flops rather than SRL primitives: every stage must clear on reset and flush.
  logic [WIDTH-1:0] sr [DEPTH];
  logic [WIDTH-1:0] tap;
  logic             tap_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
      fill <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
      fill <= '0;
    end else if (ce) begin
      sr[0] <= d;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      if (fill != FILL_MAX) fill <= fill + FILL_ONE;
    end
  end

  // The tap holds real data once at least adr+1 shifts have landed since reset/flush.
  always_comb begin
    tap       = sr[adr];
    tap_valid = (fill > {1'b0, adr});
  end

  generate
    if (OREG != 0) begin : g_oreg
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q       <= '0;
          q_valid <= 1'b0;
        end else if (flush) begin
          q       <= '0;
          q_valid <= 1'b0;
        end else begin
          q       <= tap;
          q_valid <= tap_valid;
        end
      end
    end else begin : g_comb
      always_comb begin
        q       = tap;
        q_valid = tap_valid;
      end
    end
  endgenerate

endmodule

// File: doc/srl_dly_bbl.md
Name: srl_dly_bbl

Overview:
- Parametrised successor to the fixed 16-deep parallel SRL shifter.
- Delays a WIDTH-bit parallel bus by a run-time programmable number of clock-enabled shifts, with configurable depth, optional registered output, synchronous flush, and a fill tracker.
- The fill tracker flags when the selected tap holds real data rather than reset/flush fill.
- Used in the trigger/readout path wherever CLCT, ALCT or RPC bits must be time-aligned by a programmable delay.

Parameters:
- WIDTH, 19, parallel bus width in bits.
- ADRW, 4, delay-select width; DEPTH = 2**ADRW stages (16 to 256 supported, ADRW 4..8).
- OREG, 0, 1 = register q and q_valid (adds 1 clock latency); 0 = combinational tap as in SRL16E.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  shift enable; one shift per clock with ce=1.
- flush  in  1  synchronous clear of pipeline and fill count.
- adr  in  ADRW  tap select; delay = adr+1 shifts.
- d  in  WIDTH  parallel data in.
- q  out  WIDTH  delayed data.
- q_valid  out  1  selected tap holds data shifted in since last reset/flush.
- fill  out  ADRW+1  count of valid stages, saturating at DEPTH.

Behaviour:
- Storage: DEPTH x WIDTH shift array sr[0..DEPTH-1].
  - On ce=1 and flush=0: sr[0]<=d, sr[k]<=sr[k-1].
  - On ce=0: hold.
- Tap: tap = sr[adr], i.e. data written adr+1 ce-cycles earlier. Matches SRL16E semantics for ADRW=4, OREG=0.
- adr may change on any clock. No storage disturbance; the tap moves immediately (OREG=0) or on the next edge (OREG=1).
- Fill counter:
  - Increments by 1 on each ce=1 clock while fill<DEPTH.
  - Saturates at DEPTH, no wrap.
  - Holds on ce=0.
- Validity: tap_valid = (fill > adr), unsigned compare at ADRW+1 bits.
- OREG=0: q=tap and q_valid=tap_valid, combinational from adr and state.
- OREG=1:
  - q<=tap and q_valid<=tap_valid every clock, independent of ce.
  - Latency from adr/state change to output is 1 clock.
- flush=1:
  - Next edge clears all sr stages to 0 and fill to 0.
  - The OREG output register also loads 0.
  - Flush has priority over a simultaneous ce: that clock's d is discarded and no shift occurs.
  - After flush, first valid output occurs after adr+1 further ce shifts (+1 clock if OREG).
- reset_n=0 (asynchronous, any time including mid-fill):
  - sr all 0, fill=0, q=0, q_valid=0 immediately.
  - Deassertion: first shift can occur on the first rising edge with reset_n=1.
- Reset values: q=0, q_valid=0, fill=0.
- No X propagation: every storage bit is reset.
  - Uses fabric FFs rather than SRL primitives because of the reset and flush.
  - Synthesis may pack to SRL only if reset/flush are removed; not required.
- ce toggling: delay counts shifts, not clocks. With ce duty <100%, wall-clock delay stretches accordingly.
- Boundary adr=0: delay 1 shift; q_valid after first ce.
- Boundary adr=DEPTH-1: q_valid only when fill=DEPTH.

Test Plan:
- Reset, ADRW=4, OREG=0, adr=5, ce=1 every clock, d=incrementing from 1 -> q=0 with q_valid=0 for 5 clocks after first shift; 6th shift gives q=1, q_valid=1; thereafter q=d-6; fill saturates at 16.
- OREG=1, adr=0, d=0x7ABCD single-cycle pulse then 0 -> q=0x7ABCD exactly 2 clocks after the pulse edge for one clock; q_valid rises 2 clocks after first shift.
- Steady stream at adr=3, switch adr to 10 with fill=16 -> next output equals data from 11 shifts back; q_valid stays 1. Repeat with fill=8 -> q_valid drops to 0 until fill=11.
- ce pattern 1,0,1,0 with adr=2 -> q changes only after ce clocks; delay is 3 shifts (6 clocks); fill increments only on ce=1.
- flush asserted with ce=1 at fill=16 -> next clock fill=0, q=0, q_valid=0, flushed-cycle d never appears on q. Asynchronous reset_n pulse mid-fill -> outputs zero immediately, without waiting for a clock edge.
- ADRW=8, adr=255 -> q_valid first at the 256th shift; the first word shifted in appears on q at that shift; fill reads 256 and holds.
